vga_window_ctrl: RTL and testbench

Parametrised VGA raster generator with a scalable 1-bit-per-pixel bitmap window. It produces hsync, vsync and data-enable for any timing set given by parameters, fetches bitmap words from a synchronous video memory, and expands each bit to a foreground or background colour. It drives the display pins in the peripherals subsystem. The video memory is written elsewhere by the video encoder.

---
 rtl/vga_window_ctrl.sv | 179 +++++++++++++++++
 tb/tb_vga_window_ctrl.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_window_ctrl.sv
// VGA raster generator with a scalable 1bpp bitmap window.
// Fetches bitmap words from a synchronous video memory and colours each bit.
module vga_window_ctrl #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   WIN_W      = 32,
    parameter int   WIN_H      = 10,
    parameter int   WORD_W     = 8,
    parameter int   SCALE_LOG2 = 0,
    parameter int   MEM_LAT    = 1,
    parameter int   ADDR_W     = 8,
    parameter int   RGB_W      = 8,
    parameter int   CNT_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  win_x0,
    input  logic [CNT_W-1:0]  win_y0,
    input  logic [RGB_W-1:0]  fg_color,
    input  logic [RGB_W-1:0]  bg_color,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;
    localparam int WPL     = WIN_W / WORD_W;
    localparam int BW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] WW_SCR = CNT_W'(WIN_W << SCALE_LOG2);
    localparam logic [CNT_W-1:0] WH_SCR = CNT_W'(WIN_H << SCALE_LOG2);

    typedef struct packed {
        logic          hsa;
        logic          vsa;
        logic          act;
        logic          win;
        logic          fs;
        logic [BW-1:0] bidx;
    } pix_t;

    logic [CNT_W-1:0]  hcount;
    logic [CNT_W-1:0]  vcount;

    logic              s_en;
    logic [CNT_W-1:0]  s_x0;
    logic [CNT_W-1:0]  s_y0;
    logic [RGB_W-1:0]  s_fg;
    logic [RGB_W-1:0]  s_bg;

    logic              h_act;
    logic              v_act;
    logic [CNT_W-1:0]  dx;
    logic [CNT_W-1:0]  dy;
    logic [CNT_W-1:0]  bx;
    logic [CNT_W-1:0]  by;
    logic [ADDR_W-1:0] addr;
    logic              frame0;
    pix_t              cur;
    pix_t              pipe [MEM_LAT];
    pix_t              last;

    assign frame0 = (hcount == '0) && (vcount == '0);
    assign last   = pipe[MEM_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == CNT_W'(H_TOTAL - 1)) begin
            hcount <= '0;
            if (vcount == CNT_W'(V_TOTAL - 1))
                vcount <= '0;
            else
                vcount <= vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // Window settings only change at the frame origin, so a frame never tears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_en <= 1'b0;
            s_x0 <= '0;
            s_y0 <= '0;
            s_fg <= '0;
            s_bg <= '0;
        end else if (frame0) begin
            s_en <= en;
            s_x0 <= win_x0;
            s_y0 <= win_y0;
            s_fg <= fg_color;
            s_bg <= bg_color;
        end
    end

    always_comb begin
        h_act = (hcount >= CNT_W'(HA0)) &&
                (hcount < CNT_W'(HA0 + H_ACTIVE));
        v_act = (vcount >= CNT_W'(VA0)) &&
                (vcount < CNT_W'(VA0 + V_ACTIVE));
        // Offsets below the window origin wrap to large values and fail the range test.
        dx = hcount - CNT_W'(HA0) - s_x0;
        dy = vcount - CNT_W'(VA0) - s_y0;
        bx = dx >> SCALE_LOG2;
        by = dy >> SCALE_LOG2;
        addr = ADDR_W'(32'(by) * 32'(WPL) + 32'(bx) / 32'(WORD_W));
        cur      = '0;
        cur.hsa  = hcount < CNT_W'(H_SYNC);
        cur.vsa  = vcount < CNT_W'(V_SYNC);
        cur.act  = h_act && v_act;
        cur.win  = h_act && v_act && s_en &&
                   (dx < WW_SCR) && (dy < WH_SCR);
        cur.fs   = frame0;
        cur.bidx = BW'(32'(WORD_W - 1) - 32'(bx) % 32'(WORD_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < MEM_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_rd <= cur.win;
            if (cur.win)
                mem_addr <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hs          <= last.hsa ? HS_POL : ~HS_POL;
            vs          <= last.vsa ? VS_POL : ~VS_POL;
            de          <= last.act;
            frame_start <= last.fs;
            if (!last.act)
                rgb <= '0;
            else if (last.win && mem_data[last.bidx])
                rgb <= s_fg;
            else
                rgb <= s_bg;
        end
    end

endmodule

// File: tb/tb_vga_window_ctrl.sv
// Directed bench for vga_window_ctrl on a reduced 80x30 raster.
// Two instances: unscaled (u0) and SCALE_LOG2=1 (u1).
module tb_vga_window_ctrl;

    localparam int HT  = 80;
    localparam int VT  = 30;
    localparam int FR  = HT * VT;
    localparam int P   = 2;
    localparam int HA0 = 12;
    localparam int VA0 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [10:0] win_x0 = '0;
    logic [10:0] win_y0 = '0;
    logic [7:0]  fg = '0;
    logic [7:0]  bg = '0;

    logic        rd0, hs0, vs0, de0, fs0;
    logic [7:0]  addr0, data0, rgb0;
    logic        rd1, hs1, vs1, de1, fs1;
    logic [7:0]  addr1, data1, rgb1;

    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];

    assign data0 = mem0[addr0];
    assign data1 = mem1[addr1];

    int cyc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    vga_window_ctrl #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SCALE_LOG2(0)
    ) u0 (
        .clk(clk), .rst(rst), .en(en),
        .win_x0(win_x0), .win_y0(win_y0),
        .fg_color(fg), .bg_color(bg),
        .mem_rd(rd0), .mem_addr(addr0), .mem_data(data0),
        .hs(hs0), .vs(vs0), .de(de0), .rgb(rgb0),
        .frame_start(fs0)
    );

    vga_window_ctrl #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SCALE_LOG2(1)
    ) u1 (
        .clk(clk), .rst(rst), .en(en),
        .win_x0(win_x0), .win_y0(win_y0),
        .fg_color(fg), .bg_color(bg),
        .mem_rd(rd1), .mem_addr(addr1), .mem_data(data1),
        .hs(hs1), .vs(vs1), .de(de1), .rgb(rgb1),
        .frame_start(fs1)
    );

    function automatic int px(input int f, input int v, input int h);
        return f * FR + v * HT + h + P;
    endfunction

    function automatic int st(input int f, input int v, input int h);
        return f * FR + v * HT + h + 1;
    endfunction

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 20000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (cyc != t) begin
            errors++;
            $display("FAIL wait_cyc: got cyc %0d want %0d", cyc, t);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill0(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem0[i] = v;
    endtask

    task automatic fill1(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem1[i] = v;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (hs0 !== 1'b1) begin
            errors++; $display("FAIL reset_hs: got %b want 1", hs0);
        end
        checks++;
        if (vs0 !== 1'b1) begin
            errors++; $display("FAIL reset_vs: got %b want 1", vs0);
        end
        checks++;
        if (de0 !== 1'b0) begin
            errors++; $display("FAIL reset_de: got %b want 0", de0);
        end
        checks++;
        if (rgb0 !== 8'h00) begin
            errors++; $display("FAIL reset_rgb: got %h want 00", rgb0);
        end
        checks++;
        if (fs0 !== 1'b0) begin
            errors++; $display("FAIL reset_fs: got %b want 0", fs0);
        end
        checks++;
        if (rd0 !== 1'b0 || addr0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mem: got rd %b addr %h want 0 00", rd0, addr0);
        end
    endtask

    task automatic test_timing;
        int n_hs, n_vs, n_de, n_fs, n_rd, bad_rgb;
        int hf, bad_hper, last_hf, first_hf;
        int vf, first_vf, last_vf, first_de;
        logic p_hs, p_vs;
        n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_rd = 0;
        bad_rgb = 0; hf = 0; bad_hper = 0; last_hf = 0;
        first_hf = -1; vf = 0; first_vf = -1; last_vf = -1;
        first_de = -1;
        en = 1'b0; bg = 8'h3C; fg = 8'hC3;
        win_x0 = '0; win_y0 = '0;
        do_reset;
        @(negedge clk);
        checks++;
        if (hs0 !== 1'b1 || fs0 !== 1'b0) begin
            errors++;
            $display("FAIL tim_pre: got hs %b fs %b want 1 0", hs0, fs0);
        end
        p_hs = hs0; p_vs = vs0;
        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            if (!hs0) n_hs++;
            if (!vs0) n_vs++;
            if (de0) n_de++;
            if (fs0) n_fs++;
            if (rd0) n_rd++;
            if (de0 ? (rgb0 !== bg) : (rgb0 !== 8'h00)) bad_rgb++;
            if (de0 && first_de < 0) first_de = cyc;
            if (p_hs && !hs0) begin
                if (hf > 0 && cyc - last_hf != HT) bad_hper++;
                if (hf == 0) first_hf = cyc;
                last_hf = cyc;
                hf++;
            end
            if (p_vs && !vs0) begin
                if (vf == 0) first_vf = cyc;
                last_vf = cyc;
                vf++;
            end
            p_hs = hs0; p_vs = vs0;
        end
        checks++;
        if (n_hs != 2 * VT * 8) begin
            errors++; $display("FAIL tim_hs_low: got %0d want %0d", n_hs, 2 * VT * 8);
        end
        checks++;
        if (n_vs != 2 * 2 * HT) begin
            errors++; $display("FAIL tim_vs_low: got %0d want %0d", n_vs, 4 * HT);
        end
        checks++;
        if (n_de != 2 * 64 * 24) begin
            errors++; $display("FAIL tim_de: got %0d want %0d", n_de, 2 * 64 * 24);
        end
        checks++;
        if (n_fs != 2) begin
            errors++; $display("FAIL tim_fs: got %0d want 2", n_fs);
        end
        checks++;
        if (n_rd != 0) begin
            errors++; $display("FAIL tim_rd: got %0d want 0", n_rd);
        end
        checks++;
        if (bad_rgb != 0) begin
            errors++; $display("FAIL tim_rgb: got %0d bad want 0", bad_rgb);
        end
        checks++;
        if (hf != 2 * VT || bad_hper != 0 || first_hf != P) begin
            errors++;
            $display("FAIL tim_hper: got %0d falls %0d bad first %0d want %0d 0 %0d",
                     hf, bad_hper, first_hf, 2 * VT, P);
        end
        checks++;
        if (vf != 2 || first_vf != P || last_vf - first_vf != FR) begin
            errors++;
            $display("FAIL tim_vper: got %0d falls at %0d/%0d want 2 at %0d/%0d",
                     vf, first_vf, last_vf, P, P + FR);
        end
        checks++;
        if (first_de != px(0, VA0, HA0)) begin
            errors++;
            $display("FAIL tim_de_first: got %0d want %0d", first_de, px(0, VA0, HA0));
        end
    endtask

    task automatic test_window;
        logic [7:0] pat;
        logic [7:0] exp;
        pat = 8'hA5;
        fill0(8'hFF);
        mem0[0] = 8'hA5;
        en = 1'b1; fg = 8'hF0; bg = 8'h0F;
        win_x0 = '0; win_y0 = '0;
        do_reset;
        for (int j = 0; j < 8; j++) begin
            wait_cyc(st(0, VA0 + j / 4, HA0 + 8 * (j % 4)));
            checks++;
            if (rd0 !== 1'b1 || addr0 !== 8'(j)) begin
                errors++;
                $display("FAIL win_addr%0d: got rd %b addr %0d want 1 %0d", j, rd0, addr0, j);
            end
        end
        wait_cyc(st(0, VA0 + 1, HA0 + 32));
        checks++;
        if (rd0 !== 1'b0 || addr0 !== 8'd7) begin
            errors++;
            $display("FAIL win_hold: got rd %b addr %0d want 0 7", rd0, addr0);
        end
        wait_cyc(px(1, VA0, 0));
        checks++;
        if (rgb0 !== 8'h00) begin
            errors++; $display("FAIL win_blank: got %h want 00", rgb0);
        end
        for (int j = 0; j < 8; j++) begin
            wait_cyc(px(1, VA0, HA0 + j));
            exp = pat[7-j] ? 8'hF0 : 8'h0F;
            checks++;
            if (rgb0 !== exp) begin
                errors++;
                $display("FAIL win_pix%0d: got %h want %h", j, rgb0, exp);
            end
        end
        wait_cyc(px(1, VA0, HA0 + 32));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL win_right: got %h want 0f", rgb0);
        end
        wait_cyc(px(1, VA0 + 9, HA0 + 31));
        checks++;
        if (rgb0 !== 8'hF0) begin
            errors++; $display("FAIL win_corner: got %h want f0", rgb0);
        end
        wait_cyc(px(1, VA0 + 10, HA0));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL win_below: got %h want 0f", rgb0);
        end
    endtask

    task automatic test_scale;
        int n4;
        n4 = 0;
        fill1(8'h00);
        mem1[0] = 8'h80;
        en = 1'b1; fg = 8'hF0; bg = 8'h0F;
        win_x0 = '0; win_y0 = '0;
        do_reset;
        wait_cyc(px(0, VA0, HA0));
        checks++;
        if (rgb1 !== 8'hF0) begin
            errors++; $display("FAIL scl_p00: got %h want f0", rgb1);
        end
        wait_cyc(px(0, VA0, HA0 + 1));
        checks++;
        if (rgb1 !== 8'hF0) begin
            errors++; $display("FAIL scl_p10: got %h want f0", rgb1);
        end
        wait_cyc(px(0, VA0, HA0 + 2));
        checks++;
        if (rgb1 !== 8'h0F) begin
            errors++; $display("FAIL scl_p20: got %h want 0f", rgb1);
        end
        wait_cyc(px(0, VA0 + 1, HA0));
        checks++;
        if (rgb1 !== 8'hF0) begin
            errors++; $display("FAIL scl_p01: got %h want f0", rgb1);
        end
        wait_cyc(px(0, VA0 + 1, HA0 + 1));
        checks++;
        if (rgb1 !== 8'hF0) begin
            errors++; $display("FAIL scl_p11: got %h want f0", rgb1);
        end
        for (int h = HA0; h <= HA0 + 16; h++) begin
            wait_cyc(st(0, VA0 + 2, h));
            if (rd1 && addr1 == 8'd4) n4++;
        end
        checks++;
        if (n4 != 16 || addr1 !== 8'd5) begin
            errors++;
            $display("FAIL scl_hold: got %0d cycles then %0d want 16 then 5", n4, addr1);
        end
    endtask

    task automatic test_clip;
        int n_rd, bad_rd, n_fg, s, h, v;
        n_rd = 0; bad_rd = 0; n_fg = 0;
        fill0(8'hFF);
        en = 1'b1; fg = 8'hF0; bg = 8'h0F;
        win_x0 = 11'd54; win_y0 = '0;
        do_reset;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            s = cyc - 1;
            h = s % HT;
            v = (s / HT) % VT;
            if (rd0) n_rd++;
            if (rd0 && (h < HA0 || h >= HA0 + 64 || v < VA0 || v >= VA0 + 24))
                bad_rd++;
            if (de0 && rgb0 === 8'hF0) n_fg++;
        end
        checks++;
        if (n_rd != 100) begin
            errors++; $display("FAIL clip_rd: got %0d want 100", n_rd);
        end
        checks++;
        if (bad_rd != 0) begin
            errors++; $display("FAIL clip_rd_blank: got %0d want 0", bad_rd);
        end
        checks++;
        if (n_fg != 100) begin
            errors++; $display("FAIL clip_fg: got %0d want 100", n_fg);
        end
        wait_cyc(px(1, VA0, HA0 + 53));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL clip_x53: got %h want 0f", rgb0);
        end
        wait_cyc(px(1, VA0, HA0 + 54));
        checks++;
        if (rgb0 !== 8'hF0) begin
            errors++; $display("FAIL clip_x54: got %h want f0", rgb0);
        end
        wait_cyc(px(1, VA0, HA0 + 63));
        checks++;
        if (rgb0 !== 8'hF0) begin
            errors++; $display("FAIL clip_x63: got %h want f0", rgb0);
        end
        wait_cyc(px(1, VA0, HA0 + 64));
        checks++;
        if (rgb0 !== 8'h00 || de0 !== 1'b0) begin
            errors++; $display("FAIL clip_fp: got %h de %b want 00 0", rgb0, de0);
        end
        wait_cyc(px(1, VA0 + 1, HA0));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL clip_wrap: got %h want 0f", rgb0);
        end
    endtask

    task automatic test_shadow;
        fill0(8'hFF);
        en = 1'b1; fg = 8'hF0; bg = 8'h0F;
        win_x0 = '0; win_y0 = '0;
        do_reset;
        wait_cyc(px(0, 8, 0));
        fg = 8'h55;
        win_y0 = 11'd3;
        wait_cyc(px(0, VA0 + 5, HA0));
        checks++;
        if (rgb0 !== 8'hF0) begin
            errors++; $display("FAIL shd_old_fg: got %h want f0", rgb0);
        end
        wait_cyc(px(0, VA0 + 9, HA0));
        checks++;
        if (rgb0 !== 8'hF0) begin
            errors++; $display("FAIL shd_old_y: got %h want f0", rgb0);
        end
        wait_cyc(px(0, VA0 + 10, HA0));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL shd_old_end: got %h want 0f", rgb0);
        end
        wait_cyc(px(1, 0, 0));
        checks++;
        if (fs0 !== 1'b1) begin
            errors++; $display("FAIL shd_fs: got %b want 1", fs0);
        end
        wait_cyc(px(1, VA0, HA0));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL shd_new_top: got %h want 0f", rgb0);
        end
        wait_cyc(px(1, VA0 + 3, HA0));
        checks++;
        if (rgb0 !== 8'h55) begin
            errors++; $display("FAIL shd_new_fg: got %h want 55", rgb0);
        end
        wait_cyc(px(1, VA0 + 12, HA0));
        checks++;
        if (rgb0 !== 8'h55) begin
            errors++; $display("FAIL shd_new_last: got %h want 55", rgb0);
        end
        wait_cyc(px(1, VA0 + 13, HA0));
        checks++;
        if (rgb0 !== 8'h0F) begin
            errors++; $display("FAIL shd_new_end: got %h want 0f", rgb0);
        end
    endtask

    task automatic test_reset_midline;
        fill0(8'hFF);
        en = 1'b1; fg = 8'hF0; bg = 8'h0F;
        win_x0 = '0; win_y0 = '0;
        do_reset;
        wait_cyc(px(0, VA0 + 1, HA0 + 28));
        checks++;
        if (rgb0 !== 8'hF0 || de0 !== 1'b1 || rd0 !== 1'b1 || addr0 !== 8'd7) begin
            errors++;
            $display("FAIL mid_pre: got rgb %h de %b rd %b addr %0d want f0 1 1 7",
                     rgb0, de0, rd0, addr0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (hs0 !== 1'b1 || vs0 !== 1'b1 || de0 !== 1'b0 || fs0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_sync: got hs %b vs %b de %b fs %b want 1 1 0 0",
                     hs0, vs0, de0, fs0);
        end
        checks++;
        if (rgb0 !== 8'h00 || rd0 !== 1'b0 || addr0 !== 8'h00) begin
            errors++;
            $display("FAIL mid_async_data: got rgb %h rd %b addr %h want 00 0 00",
                     rgb0, rd0, addr0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (hs0 !== 1'b1 || de0 !== 1'b0) begin
            errors++; $display("FAIL mid_hold: got hs %b de %b want 1 0", hs0, de0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (hs0 !== 1'b1) begin
            errors++; $display("FAIL mid_hs_c1: got %b want 1", hs0);
        end
        @(negedge clk);
        checks++;
        if (hs0 !== 1'b0 || fs0 !== 1'b1 || vs0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_c2: got hs %b fs %b vs %b want 0 1 0", hs0, fs0, vs0);
        end
        wait_cyc(px(0, 0, 7));
        checks++;
        if (hs0 !== 1'b0) begin
            errors++; $display("FAIL mid_hs_h7: got %b want 0", hs0);
        end
        wait_cyc(px(0, 0, 8));
        checks++;
        if (hs0 !== 1'b1) begin
            errors++; $display("FAIL mid_hs_h8: got %b want 1", hs0);
        end
        wait_cyc(px(0, 1, HT - 1));
        checks++;
        if (vs0 !== 1'b0) begin
            errors++; $display("FAIL mid_vs_end: got %b want 0", vs0);
        end
        wait_cyc(px(0, 2, 0));
        checks++;
        if (vs0 !== 1'b1) begin
            errors++; $display("FAIL mid_vs_off: got %b want 1", vs0);
        end
        wait_cyc(px(0, VA0, HA0 - 1));
        checks++;
        if (de0 !== 1'b0) begin
            errors++; $display("FAIL mid_de_pre: got %b want 0", de0);
        end
        wait_cyc(px(0, VA0, HA0));
        checks++;
        if (de0 !== 1'b1 || rgb0 !== 8'hF0) begin
            errors++;
            $display("FAIL mid_de_first: got de %b rgb %h want 1 f0", de0, rgb0);
        end
    endtask

    initial begin
        fill0(8'h00);
        fill1(8'h00);
        test_reset;
        test_timing;
        test_window;
        test_scale;
        test_clip;
        test_shadow;
        test_reset_midline;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
